// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Word width, FSM states and access owner encoding.
package mem_arbiter_pkg;

  localparam int WORD_W = 24;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM bundle seen by the memory arbiter.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  if_req;
  word_t if_addr;
  logic  if_flush;
  logic  dm_req;
  logic  dm_we;
  word_t dm_addr;
  word_t dm_wdata;
  word_t ram_rdata;
  logic  ram_en;
  logic  ram_we;
  word_t ram_addr;
  word_t ram_wdata;
  word_t if_rdata;
  word_t dm_rdata;
  logic  if_valid;
  logic  dm_valid;
  logic  stall_if;
  logic  stall_mem;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  ram_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output if_rdata, dm_rdata,
    output if_valid, dm_valid,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output ram_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  if_rdata, dm_rdata,
    input  if_valid, dm_valid,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Read-latency down-counter for the memory arbiter.
// Parks at zero; expired is high whenever the count is zero.
module lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data stages.
// One access in flight; DM priority with IF anti-starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t        state;
  state_t        stateNext;
  owner_t        owner;
  logic          drop;
  logic [SW-1:0] starveCnt;
  word_t         addrReg;
  word_t         wdataReg;
  word_t         ifRdata;
  word_t         dmRdata;
  logic          grantAny;
  logic          grantIf;
  logic          grantDm;
  logic          grantSt;
  logic          expired;
  logic          ifValid;
  logic          dmValid;

  always_comb begin
    grantAny = rst_n && state == IDLE &&
               (bus.if_req || bus.dm_req);
    grantIf  = grantAny && bus.if_req &&
               (!bus.dm_req || starveCnt == STARVE_TOP);
    grantDm  = grantAny && !grantIf;
    grantSt  = grantDm && bus.dm_we;
    stateNext = state;
    unique case (state)
      IDLE:    if (grantAny) stateNext = grantSt ? DONE : RD_WAIT;
      RD_WAIT: if (expired) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  lat_counter #(.W(3)) u_lat (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grantAny && !grantSt),
    .loadVal (LAT_LOAD),
    .dec     (state == RD_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      starveCnt <= '0;
      addrReg   <= '0;
      wdataReg  <= '0;
      ifRdata   <= '0;
      dmRdata   <= '0;
    end else begin
      state <= stateNext;
      if (grantAny) begin
        owner    <= grantIf ? OWN_IF : OWN_DM;
        addrReg  <= grantIf ? bus.if_addr : bus.dm_addr;
        wdataReg <= grantDm ? bus.dm_wdata : '0;
      end
      if (grantIf) begin
        starveCnt <= '0;
      end else if (grantDm && bus.if_req &&
                   starveCnt != STARVE_TOP) begin
        starveCnt <= starveCnt + 1'b1;
      end
      // A flushed fetch still drains the RAM; only its valid is hidden.
      if (state == DONE) begin
        drop <= 1'b0;
      end else if (bus.if_flush &&
                   (grantIf ||
                    (state == RD_WAIT && owner == OWN_IF))) begin
        drop <= 1'b1;
      end
      if (state == RD_WAIT && expired) begin
        if (owner == OWN_IF) ifRdata <= bus.ram_rdata;
        else                 dmRdata <= bus.ram_rdata;
      end
    end
  end

  always_comb begin
    bus.ram_en    = grantAny;
    bus.ram_we    = grantSt;
    bus.ram_addr  = addrReg;
    bus.ram_wdata = wdataReg;
    unique case (1'b1)
      grantIf: begin
        bus.ram_addr  = bus.if_addr;
        bus.ram_wdata = '0;
      end
      grantDm: begin
        bus.ram_addr  = bus.dm_addr;
        bus.ram_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
  end

  assign ifValid = state == DONE && owner == OWN_IF && !drop;
  assign dmValid = state == DONE && owner == OWN_DM;

  assign bus.if_valid  = ifValid;
  assign bus.dm_valid  = dmValid;
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;
  assign bus.stall_if  = bus.if_req && !ifValid;
  assign bus.stall_mem = bus.dm_req && !dmValid;

endmodule
